// File: rtl/mont_exit.sv
// mont_exit: bit-serial Montgomery-domain exit converter (x*R^-1 mod p, R = 2^datawidth).
// One reduction step per clock, valid/ready on both sides.
// Optional MONT_ENTRY_EN: adds the entry step (x*R mod p) selected by the mode input.
`ifndef DATAWIDTH
`define DATAWIDTH 16
`endif

module mont_exit #(
  parameter int datawidth = `DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [datawidth-1:0] x,
  input  logic [datawidth-1:0] p,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [datawidth-1:0] out,
  output logic                 busy
);

  localparam int CW = (datawidth > 1) ? $clog2(datawidth) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nx;
  logic [datawidth:0]   t, t_nx;
  logic [datawidth:0]   t_sum, t_exit;
  logic [datawidth-1:0] p_q, out_r;
  logic [CW-1:0]        cnt;
  logic                 last;

  assign last = (cnt == CW'(datawidth - 1));

  // Exit step: add p when odd so the halving is exact; t stays below p.
  assign t_sum  = t + {1'b0, p_q};
  assign t_exit = t[0] ? (t_sum >> 1) : (t >> 1);

`ifdef MONT_ENTRY_EN
  logic               mode_q;
  logic [datawidth:0] t_dbl, t_ent;
  // Entry step: modular doubling; t < p keeps the doubled value within datawidth+1 bits.
  assign t_dbl = {t[datawidth-1:0], 1'b0};
  assign t_ent = (t_dbl >= {1'b0, p_q}) ? (t_dbl - {1'b0, p_q}) : t_dbl;
  assign t_nx  = mode_q ? t_ent : t_exit;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign t_nx        = t_exit;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: accept in IDLE, datawidth steps in RUN, hold in DONE until taken.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load operands on accept, step the accumulator, register the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t     <= '0;
      p_q   <= '0;
      cnt   <= '0;
      out_r <= '0;
`ifdef MONT_ENTRY_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          t   <= {1'b0, x};
          p_q <= p;
          cnt <= '0;
`ifdef MONT_ENTRY_EN
          mode_q <= mode;
`endif
        end
        RUN: begin
          t   <= t_nx;
          cnt <= cnt + CW'(1);
          if (last) out_r <= t_nx[datawidth-1:0];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out       = out_r;

endmodule

// File: tb/tb_mont_exit.sv
// tb_mont_exit: directed self-checking bench for mont_exit (datawidth = 16, p = 12289).
// Entry/round-trip scenarios are compiled when MONT_ENTRY_EN is defined.
module tb_mont_exit;

  localparam int DW = 16;
  localparam logic [DW-1:0] P = 16'd12289;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x;
  logic [DW-1:0] p;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  mont_exit #(.datawidth(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .p(p), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Plain a with a*4091 mod p == v (4091 = R mod p), found by search.
  function automatic logic [DW-1:0] exit_ref(input int v);
    for (int a = 0; a < 12289; a++)
      if ((a * 4091) % 12289 == v) return DW'(a);
    return '1;
  endfunction

  // Drive one transaction with out_ready high; report result, latency and whether it completed.
  task automatic do_op(input logic [DW-1:0] xv, input logic mv,
                       output logic [DW-1:0] res, output int lat, output bit ok);
    int w;
    x = xv; p = P; mode = mv; out_ready = 1'b1; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    ok  = out_valid && (w < 100);
    res = out;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; p = P; mode = 1'b0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out !== '0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b out=%0d, required 1 0 0 0",
               in_ready, out_valid, busy, out);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exit;
    logic [DW-1:0] xs [3] = '{16'd4091, 16'd8182, 16'd0};
    logic [DW-1:0] es [3] = '{16'd1, 16'd2, 16'd0};
    logic [DW-1:0] r;
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      do_op(xs[i], 1'b0, r, lat, ok);
      n_cmp++;
      if (!ok || r !== es[i]) begin
        n_err++;
        $display("FAIL exit_value x=%0d: got %0d (done=%0b), required %0d", xs[i], r, ok, es[i]);
      end
      n_cmp++;
      if (lat != 16) begin
        n_err++;
        $display("FAIL exit_latency x=%0d: got %0d edges, required 16", xs[i], lat);
      end
    end
  endtask

  task automatic test_backpressure;
    int w;
    x = 16'd4091; p = P; mode = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 16'd8182;                       // second request held on in_valid
    w = 0;
    while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (!out_valid) begin
      n_err++;
      $display("FAIL bp_done: out_valid=%b after %0d cycles, required 1", out_valid, w);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 16'd1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: out_valid=%b out=%0d in_ready=%b, required 1 1 0",
                 c, out_valid, out, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out !== 16'd1) begin
      n_err++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b out=%0d, required 0 1 0 1",
               out_valid, in_ready, busy, out);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] xs [3];
    logic [DW-1:0] es [3];
    logic [DW-1:0] got [3];
    int acc_t [3];
    int idx, oidx;
    bit acc;
    xs = '{16'd4091, 16'd8182, 16'd12288};
    es = '{16'd1, 16'd2, exit_ref(12288)};
    idx = 0; oidx = 0;
    p = P; mode = 1'b0; out_ready = 1'b1; x = xs[0]; in_valid = 1'b1;
    for (int c = 0; c < 200 && oidx < 3; c++) begin
      acc = in_ready && in_valid;
      @(posedge clk); #1;
      if (acc) begin
        acc_t[idx] = c; idx++;
        if (idx < 3) x = xs[idx];
        else in_valid = 1'b0;
      end
      if (out_valid) begin got[oidx] = out; oidx++; end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (oidx != 3) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, required 3", oidx);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got[i] !== es[i]) begin
          n_err++;
          $display("FAIL b2b_value x=%0d: got %0d, required %0d", xs[i], got[i], es[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (acc_t[i] - acc_t[i-1] != 18) begin
          n_err++;
          $display("FAIL b2b_spacing %0d: got %0d cycles, required 18", i, acc_t[i] - acc_t[i-1]);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    logic [DW-1:0] r;
    int lat;
    bit ok;
    x = 16'd8182; p = P; mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out !== '0) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b out=%0d, required 0 0 1 0",
               out_valid, busy, in_ready, out);
    end
    #1; rst = 1'b0;
    do_op(16'd4091, 1'b0, r, lat, ok);
    n_cmp++;
    if (!ok || r !== 16'd1 || lat != 16) begin
      n_err++;
      $display("FAIL after_reset: got %0d latency %0d, required 1 latency 16", r, lat);
    end
  endtask

`ifdef MONT_ENTRY_EN
  task automatic test_entry;
    logic [DW-1:0] r, m;
    int lat;
    bit ok;
    do_op(16'd1, 1'b1, r, lat, ok);
    n_cmp++;
    if (!ok || r !== 16'd4091 || lat != 16) begin
      n_err++;
      $display("FAIL entry_1: got %0d latency %0d, required 4091 latency 16", r, lat);
    end
    do_op(16'd2, 1'b1, r, lat, ok);
    n_cmp++;
    if (!ok || r !== 16'd8182) begin
      n_err++;
      $display("FAIL entry_2: got %0d, required 8182", r);
    end
    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] xv;
      xv = DW'($urandom_range(12288, 0));
      do_op(xv, 1'b1, m, lat, ok);
      do_op(m, 1'b0, r, lat, ok);
      n_cmp++;
      if (!ok || r !== xv) begin
        n_err++;
        $display("FAIL round_trip x=%0d: mid %0d got %0d, required %0d", xv, m, r, xv);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_exit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MONT_ENTRY_EN
    test_entry();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
